// File: rtl/down_cntr_timer.sv
// Programmable down-counter/timer with one-shot and auto-reload modes.
// Emits a single-cycle terminal-count pulse on every transition to zero.
module down_cntr_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_en,
    input  logic             i_periodic,
    output logic [WIDTH-1:0] o_cntr,
    output logic             o_busy,
    output logic             o_tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_cntr;
    logic [WIDTH-1:0] w_nextCntr;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_nextReload;
    logic             r_mode;
    logic             w_nextMode;
    logic             r_tc;
    logic             w_nextTc;
    logic             w_cntrIsZero;
    logic             w_cntrIsOne;

    assign w_cntrIsZero = (r_cntr == '0);
    assign w_cntrIsOne  = (r_cntr == WIDTH'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cntr   <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_cntr   <= w_nextCntr;
            r_reload <= w_nextReload;
            r_mode   <= w_nextMode;
            r_tc     <= w_nextTc;
        end
    end

    // Priority chain: load, then stop, then start, then counting.
    always_comb begin
        w_nextState  = r_state;
        w_nextCntr   = r_cntr;
        w_nextReload = r_reload;
        w_nextMode   = r_mode;
        w_nextTc     = 1'b0;

        if (i_load) begin
            w_nextCntr   = i_load_val;
            w_nextReload = i_load_val;
            w_nextState  = IDLE;
        end else if (i_stop && (r_state == RUN)) begin
            w_nextState = IDLE;
        end else if (i_start && (r_state == IDLE) && !w_cntrIsZero) begin
            w_nextState = RUN;
            w_nextMode  = i_periodic;
        end else if ((r_state == RUN) && i_en) begin
            if (w_cntrIsZero) begin
                // Only reachable in periodic mode: the extra reload cycle
                // makes the period N+1 edges.
                if (r_mode) begin
                    w_nextCntr = r_reload;
                end else begin
                    w_nextState = IDLE;
                end
            end else if (w_cntrIsOne) begin
                w_nextCntr = '0;
                w_nextTc   = 1'b1;
                if (!r_mode) begin
                    w_nextState = IDLE;
                end
            end else begin
                w_nextCntr = r_cntr - WIDTH'(1);
            end
        end
    end

    assign o_cntr = r_cntr;
    assign o_busy = (r_state == RUN);
    assign o_tc   = r_tc;

endmodule

// File: tb/tb_down_cntr_timer.sv
// Scoreboard bench for down_cntr_timer: a driver pushes model predictions
// into a queue and an independent monitor pops and compares every cycle.
module tb_down_cntr_timer;

    localparam int WIDTH = 4;

    typedef struct {
        int cntr;
        int busy;
        int tc;
    } expect_t;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] loadVal;
    logic             start;
    logic             stop;
    logic             en;
    logic             periodic;
    logic [WIDTH-1:0] cntr;
    logic             busy;
    logic             tc;

    expect_t sbQueue[$];
    int      checkCount;
    int      failCount;

    // Reference model state, kept as plain integers
    int  mCount;
    int  mReload;
    bit  mRunning;
    bit  mPeriodic;
    bit  mTc;

    down_cntr_timer #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (load),
        .i_load_val (loadVal),
        .i_start    (start),
        .i_stop     (stop),
        .i_en       (en),
        .i_periodic (periodic),
        .o_cntr     (cntr),
        .o_busy     (busy),
        .o_tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelStep(input bit r, input bit ld, input int val, input bit st,
                             input bit sp, input bit e, input bit per);
        mTc = 1'b0;
        if (r) begin
            mCount    = 0;
            mReload   = 0;
            mRunning  = 1'b0;
            mPeriodic = 1'b0;
        end else if (ld) begin
            mCount   = val;
            mReload  = val;
            mRunning = 1'b0;
        end else if (sp && mRunning) begin
            mRunning = 1'b0;
        end else if (st && !mRunning && mCount != 0) begin
            mRunning  = 1'b1;
            mPeriodic = per;
        end else if (mRunning && e) begin
            if (mCount == 0) begin
                mCount = mReload;
            end else begin
                mCount = mCount - 1;
                if (mCount == 0) begin
                    mTc = 1'b1;
                    if (!mPeriodic) mRunning = 1'b0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ld, input int val, input bit st,
                                 input bit sp, input bit e, input bit per);
        expect_t ex;
        @(negedge clk);
        rst      = r;
        load     = ld;
        loadVal  = WIDTH'(val);
        start    = st;
        stop     = sp;
        en       = e;
        periodic = per;
        modelStep(r, ld, val, st, sp, e, per);
        ex.cntr = mCount;
        ex.busy = int'(mRunning);
        ex.tc   = int'(mTc);
        sbQueue.push_back(ex);
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, e, 0);
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        checkCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, required);
        end
    endtask

    // Monitor: the DUT presents a result on every edge, so pop one per cycle
    initial begin
        expect_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (sbQueue.size() > 0) begin
                ex = sbQueue.pop_front();
                checkOutput("cntr", int'(cntr), ex.cntr);
                checkOutput("busy", int'(busy), ex.busy);
                checkOutput("tc",   int'(tc),   ex.tc);
            end
        end
    end

    initial begin
        checkCount = 0;
        failCount  = 0;
        mCount = 0; mReload = 0; mRunning = 0; mPeriodic = 0; mTc = 0;
        rst = 1'b1; load = 0; loadVal = '0; start = 0; stop = 0; en = 0; periodic = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        idle(2, 1);

        // One-shot from 5
        applyStimulus(0, 1, 5, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        idle(8, 1);

        // Periodic from 3
        applyStimulus(0, 1, 3, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        idle(12, 1);

        // Pause pattern
        applyStimulus(0, 1, 4, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        idle(5, 1);

        // Stop then restart
        applyStimulus(0, 1, 6, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        idle(2, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        idle(2, 1);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        idle(6, 1);

        // Stop and load on the edge where the count would reach zero
        applyStimulus(0, 1, 2, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        applyStimulus(0, 1, 9, 0, 0, 1, 0);

        // Full-range periodic, then reset mid-count; then load 0 and start
        applyStimulus(0, 1, 15, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        idle(24, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        idle(2, 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        idle(2, 1);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 14) == 0,
                          int'($urandom_range(0, 15)),
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1);
        end

        @(posedge clk);
        #3;
        checkOutput("scoreboard drained", sbQueue.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/down_cntr_timer.md
# down_cntr_timer

Programmable down-counter/timer that complements the free-running up counter in the same counter library. It counts down from a loaded value to zero and supports one-shot and periodic (auto-reload) modes. A one-cycle terminal-count pulse is used as a timeout/tick source by neighbouring control logic. Single clock domain, fully registered outputs.

## Interface
- WIDTH, 4, counter and load-value width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- load  input  1  capture load_val into counter and reload register
- load_val  input  WIDTH  value for load
- start  input  1  begin counting (sampled in IDLE only)
- stop  input  1  abort counting, return to IDLE
- en  input  1  count enable while running; low = pause
- periodic  input  1  mode, latched at accepted start: 1 = auto-reload, 0 = one-shot
- cntr  output  WIDTH  current count
- busy  output  1  high in RUN state
- tc  output  1  terminal-count pulse, one cycle

## Operation
- State register: IDLE, RUN. Internal regs: reload_reg[WIDTH], mode_reg.
- Per-edge priority: rst > load > stop > start > count.
- rst: cntr=0, reload_reg=0, mode_reg=0, state=IDLE, busy=0, tc=0.
- load (any state): cntr<=load_val, reload_reg<=load_val, state<=IDLE, tc<=0. A start in the same cycle is ignored.
- stop in RUN: state<=IDLE, cntr holds, tc<=0. stop in IDLE: no effect.
- start in IDLE with cntr≠0: state<=RUN, mode_reg<=periodic, cntr unchanged. start with cntr==0 is ignored. start in RUN is ignored.
- RUN, en=0: cntr, state, and mode hold. tc=0.
- RUN, en=1, cntr>1: cntr<=cntr-1.
- RUN, en=1, cntr==1: cntr<=0, tc<=1.
  - One-shot: state<=IDLE on the same edge.
  - Periodic: remain in RUN.
- RUN, en=1, cntr==0 (periodic only): cntr<=reload_reg, tc<=0.
- Arithmetic: unsigned. The counter never decrements below 0 and never wraps to all-ones.
- tc is 0 in every cycle not covered above. It is high exactly one cycle per zero-crossing.
- busy is a pure decode of state==RUN.

## Timing
- All outputs are registered and change only on the rising clk edge.
- start accepted at edge k: busy=1 after k. First decrement at edge k+1 if en=1.
- One-shot from value N with en held high: cntr reaches 0 at edge k+N.
  - tc=1 and busy=0 in the cycle after edge k+N.
  - Total of N count cycles after start acceptance.
- Periodic from N with en held high:
  - tc pulses at edges k+N, k+2N+1, k+3N+2, … (period N+1 cycles).
  - cntr sequence: N, N-1, …, 1, 0, N, …
- Pausing with en=0 extends all subsequent edges by the number of paused cycles. No count is lost or duplicated.
- stop or load on the same edge where cntr would reach 0: no tc; stop/load behaviour applies.
- rst during RUN: all outputs are at reset values after that edge, with no tc.
- load_val=0 followed by start: start is ignored; busy stays 0.

## Test plan
- rst high 2 cycles -> cntr=0, busy=0, tc=0. start with cntr=0 -> busy stays 0.
- load 5, start, periodic=0, en=1 -> cntr 5,4,3,2,1,0. tc=1 for exactly one cycle, coincident with cntr=0 and busy falling. Afterwards cntr holds 0.
- load 3, start, periodic=1, en=1 for 12 cycles -> cntr 3,2,1,0,3,2,1,0,…. tc every 4 cycles, busy constantly 1.
- load 4, start, en toggled 1,0,0,1,1,1 -> cntr 4,3,3,3,2,1,0. tc on the final cycle only.
- load 6, start, stop after 2 decrements -> busy=0, cntr holds 4, no tc. Then start again -> resumes 4,3,2,1,0 with tc.
- WIDTH=4, load 15, periodic=1 -> period 16 cycles. rst asserted mid-count -> cntr=0, busy=0, tc=0 on the next edge.
